// File: rtl/axis_fifo_if.sv
// AXI-Stream link bundle shared by transmitter and receiver ends.
// Latency: none, wires only.
// Backpressure: tready from receiver to transmitter; tvalid holds until accepted.
interface AXIS_IF #(
    parameter int TDATA_WIDTH = 8,
    parameter int TUSER_WIDTH = 1,
    parameter int TID_WIDTH   = 1,
    parameter int TDEST_WIDTH = 1
);
    localparam int TKEEP_WIDTH = (TDATA_WIDTH + 7) / 8;

    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;
    logic [TKEEP_WIDTH-1:0] tkeep;
    logic [TKEEP_WIDTH-1:0] tstrb;
    logic                   tlast;
    logic [TUSER_WIDTH-1:0] tuser;
    logic [TID_WIDTH-1:0]   tid;
    logic [TDEST_WIDTH-1:0] tdest;
    logic                   twakeup;

    modport Transmitter (
        output tvalid, tdata, tkeep, tstrb, tlast, tuser, tid, tdest, twakeup,
        input  tready
    );

    modport Receiver (
        input  tvalid, tdata, tkeep, tstrb, tlast, tuser, tid, tdest, twakeup,
        output tready
    );
endinterface

// File: rtl/axis_fifo.sv
// Single-clock AXI-Stream beat FIFO with optional whole-frame release.
// Latency: beat visible the cycle after its write (frame mode: after the frame's tlast write).
// Backpressure: s_axis.tready low when full; m_axis.tvalid held until accepted.
module axis_fifo #(
    parameter int DEPTH       = 16,
    parameter bit FRAME_MODE  = 1'b0,
    parameter int TDATA_WIDTH = 8,
    parameter int TUSER_WIDTH = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    AXIS_IF.Receiver                 s_axis,
    AXIS_IF.Transmitter              m_axis,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int KW = (TDATA_WIDTH + 7) / 8;

    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef struct packed {
        logic [TDATA_WIDTH-1:0] tdata;
        logic [KW-1:0]          tkeep;
        logic                   tlast;
        logic [TUSER_WIDTH-1:0] tuser;
    } beat_t;

    // Parameter sanity: catch mis-sized instances at elaboration.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("axis_fifo: DEPTH must be a power of two and at least 2");
    end
    if (($bits(s_axis.tdata) != TDATA_WIDTH) || ($bits(m_axis.tdata) != TDATA_WIDTH)) begin : g_bad_tdata
        $error("axis_fifo: TDATA_WIDTH does not match attached interfaces");
    end
    if (($bits(s_axis.tuser) != TUSER_WIDTH) || ($bits(m_axis.tuser) != TUSER_WIDTH)) begin : g_bad_tuser
        $error("axis_fifo: TUSER_WIDTH does not match attached interfaces");
    end
    if (($bits(s_axis.tkeep) != KW) || ($bits(m_axis.tkeep) != KW)) begin : g_bad_tkeep
        $error("axis_fifo: tkeep width does not match TDATA_WIDTH");
    end

    beat_t          mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           wr_en;
    logic           rd_en;
    logic           out_vld;
    beat_t          wr_beat;
    beat_t          rd_beat;

    // Sideband inputs we deliberately drop; folded here so they are visibly consumed.
    logic unused_sideband;
    assign unused_sideband = ^{s_axis.tstrb, s_axis.tid, s_axis.tdest, s_axis.twakeup};

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    assign s_axis.tready = rst_n && !full;
    assign wr_en         = s_axis.tvalid && s_axis.tready;
    assign rd_en         = m_axis.tvalid && m_axis.tready;

    assign wr_beat.tdata = s_axis.tdata;
    assign wr_beat.tkeep = s_axis.tkeep;
    assign wr_beat.tlast = s_axis.tlast;
    assign wr_beat.tuser = s_axis.tuser;

    // Output is read straight from the head entry; no output register.
    assign rd_beat = mem[rd_ptr];

    assign m_axis.tvalid  = rst_n && out_vld;
    assign m_axis.tdata   = rd_beat.tdata;
    assign m_axis.tkeep   = rd_beat.tkeep;
    assign m_axis.tstrb   = rd_beat.tkeep;
    assign m_axis.tlast   = rd_beat.tlast;
    assign m_axis.tuser   = rd_beat.tuser;
    assign m_axis.tid     = '0;
    assign m_axis.tdest   = '0;
    assign m_axis.twakeup = 1'b0;

    // Storage write; contents need no reset since occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_beat;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    if (FRAME_MODE) begin : g_frame
        logic [CW-1:0] frames;
        logic          frame_in;
        logic          frame_out;

        assign frame_in  = wr_en && s_axis.tlast;
        assign frame_out = rd_en && rd_beat.tlast;

        // Count of complete frames held; only a read can lower it, so tvalid never retracts.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                frames <= '0;
            end else begin
                case ({frame_in, frame_out})
                    2'b10:   frames <= frames + CNT_ONE;
                    2'b01:   frames <= frames - CNT_ONE;
                    default: frames <= frames;
                endcase
            end
        end

        // Full override lets frames larger than the FIFO stream out instead of deadlocking.
        assign out_vld = !empty && ((frames != '0) || full);
    end else begin : g_stream
        assign out_vld = !empty;
    end
endmodule

// File: tb/tb_axis_fifo.sv
// Directed bench for axis_fifo: stream, frame-hold and oversize-frame instances.
// Latency: checks sampled on the falling edge after each write/read edge.
// Backpressure: downstream tready driven per scenario to force full/empty corners.
module tb_axis_fifo;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    AXIS_IF #(.TDATA_WIDTH(8), .TUSER_WIDTH(1)) s0 ();
    AXIS_IF #(.TDATA_WIDTH(8), .TUSER_WIDTH(1)) m0 ();
    AXIS_IF #(.TDATA_WIDTH(8), .TUSER_WIDTH(1)) s1 ();
    AXIS_IF #(.TDATA_WIDTH(8), .TUSER_WIDTH(1)) m1 ();
    AXIS_IF #(.TDATA_WIDTH(8), .TUSER_WIDTH(1)) s2 ();
    AXIS_IF #(.TDATA_WIDTH(8), .TUSER_WIDTH(1)) m2 ();

    logic [4:0] count0, count1;
    logic [3:0] count2;
    logic       full0, full1, full2, empty0, empty1, empty2;

    axis_fifo #(.DEPTH(16), .FRAME_MODE(1'b0), .TDATA_WIDTH(8), .TUSER_WIDTH(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .s_axis(s0), .m_axis(m0),
        .count(count0), .full(full0), .empty(empty0));
    axis_fifo #(.DEPTH(16), .FRAME_MODE(1'b1), .TDATA_WIDTH(8), .TUSER_WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .s_axis(s1), .m_axis(m1),
        .count(count1), .full(full1), .empty(empty1));
    axis_fifo #(.DEPTH(8), .FRAME_MODE(1'b1), .TDATA_WIDTH(8), .TUSER_WIDTH(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .s_axis(s2), .m_axis(m2),
        .count(count2), .full(full2), .empty(empty2));

    task automatic test_reset();
        s0.tvalid = 0; s0.tdata = 0; s0.tkeep = 1; s0.tstrb = 0; s0.tlast = 0; s0.tuser = 0;
        s0.tid = 0; s0.tdest = 0; s0.twakeup = 0; m0.tready = 0;
        s1.tvalid = 0; s1.tdata = 0; s1.tkeep = 1; s1.tstrb = 0; s1.tlast = 0; s1.tuser = 0;
        s1.tid = 0; s1.tdest = 0; s1.twakeup = 0; m1.tready = 0;
        s2.tvalid = 0; s2.tdata = 0; s2.tkeep = 1; s2.tstrb = 0; s2.tlast = 0; s2.tuser = 0;
        s2.tid = 0; s2.tdest = 0; s2.twakeup = 0; m2.tready = 0;
        rst_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (count0 !== 5'd0) $display("FAIL rst_count got %0d exp 0", count0); else passed++;
        checks++; if (empty0 !== 1'b1) $display("FAIL rst_empty got %b exp 1", empty0); else passed++;
        checks++; if (full0 !== 1'b0) $display("FAIL rst_full got %b exp 0", full0); else passed++;
        checks++; if (m0.tvalid !== 1'b0) $display("FAIL rst_tvalid got %b exp 0", m0.tvalid); else passed++;
        checks++; if (s0.tready !== 1'b0) $display("FAIL rst_tready_low got %b exp 0", s0.tready); else passed++;
        checks++; if (count2 !== 4'd0) $display("FAIL rst_count2 got %0d exp 0", count2); else passed++;
        rst_n = 1;
        @(negedge clk);
        checks++; if (s0.tready !== 1'b1) $display("FAIL rst_tready_rel got %b exp 1", s0.tready); else passed++;
        checks++; if (s2.tready !== 1'b1) $display("FAIL rst_tready_rel2 got %b exp 1", s2.tready); else passed++;
    endtask

    task automatic test_passthrough();
        m0.tready = 1;
        for (int i = 0; i <= 5; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++; if (m0.tvalid !== 1'b1) $display("FAIL pt_tvalid[%0d] got %b exp 1", i, m0.tvalid); else passed++;
                checks++; if (m0.tdata !== 8'(i)) $display("FAIL pt_data[%0d] got %h exp %h", i, m0.tdata, 8'(i)); else passed++;
                checks++; if (m0.tlast !== (i == 5)) $display("FAIL pt_tlast[%0d] got %b exp %b", i, m0.tlast, (i == 5)); else passed++;
                checks++; if (m0.tuser !== 1'(i)) $display("FAIL pt_tuser[%0d] got %b exp %b", i, m0.tuser, 1'(i)); else passed++;
                checks++; if (m0.tstrb !== 1'b1) $display("FAIL pt_tstrb[%0d] got %b exp 1", i, m0.tstrb); else passed++;
                checks++; if (count0 !== 5'd1) $display("FAIL pt_count[%0d] got %0d exp 1", i, count0); else passed++;
            end
            if (i < 5) begin
                s0.tvalid = 1; s0.tdata = 8'(i + 1); s0.tlast = (i == 4); s0.tuser = 1'(i + 1);
            end else begin
                s0.tvalid = 0; s0.tlast = 0;
            end
        end
        @(negedge clk);
        checks++; if (count0 !== 5'd0) $display("FAIL pt_count_end got %0d exp 0", count0); else passed++;
        checks++; if (m0.tvalid !== 1'b0) $display("FAIL pt_tvalid_end got %b exp 0", m0.tvalid); else passed++;
    endtask

    task automatic test_fill();
        int acc;
        acc = 0;
        m0.tready = 0;
        s0.tlast = 0; s0.tuser = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            s0.tvalid = 1; s0.tdata = 8'(8'h10 + acc);
            if (s0.tready) acc++;
        end
        @(negedge clk);
        checks++; if (acc !== 16) $display("FAIL fill_accepted got %0d exp 16", acc); else passed++;
        checks++; if (count0 !== 5'd16) $display("FAIL fill_count got %0d exp 16", count0); else passed++;
        checks++; if (full0 !== 1'b1) $display("FAIL fill_full got %b exp 1", full0); else passed++;
        checks++; if (s0.tready !== 1'b0) $display("FAIL fill_tready got %b exp 0", s0.tready); else passed++;
        checks++; if (m0.tdata !== 8'h10) $display("FAIL fill_head got %h exp 10", m0.tdata); else passed++;
        s0.tdata = 8'h20;
        m0.tready = 1;
        @(negedge clk);
        m0.tready = 0;
        checks++; if (count0 !== 5'd15) $display("FAIL fill_after_read got %0d exp 15", count0); else passed++;
        checks++; if (s0.tready !== 1'b1) $display("FAIL fill_tready_back got %b exp 1", s0.tready); else passed++;
        @(negedge clk);
        checks++; if (count0 !== 5'd16) $display("FAIL fill_beat17 got %0d exp 16", count0); else passed++;
        s0.tvalid = 0;
        m0.tready = 1;
        for (int i = 0; i < 16; i++) begin
            checks++; if (m0.tdata !== 8'(8'h11 + i)) $display("FAIL fill_drain[%0d] got %h exp %h", i, m0.tdata, 8'(8'h11 + i)); else passed++;
            @(negedge clk);
        end
        checks++; if (empty0 !== 1'b1) $display("FAIL fill_empty got %b exp 1", empty0); else passed++;
    endtask

    task automatic test_back_to_back();
        m0.tready = 1;
        s0.tlast = 0; s0.tuser = 0;
        for (int i = 0; i <= 40; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checks++; if (m0.tvalid !== 1'b1) $display("FAIL b2b_tvalid[%0d] got %b exp 1", i, m0.tvalid); else passed++;
                checks++; if (m0.tdata !== 8'(8'h40 + i - 1)) $display("FAIL b2b_data[%0d] got %h exp %h", i, m0.tdata, 8'(8'h40 + i - 1)); else passed++;
                checks++; if (count0 !== 5'd1) $display("FAIL b2b_count[%0d] got %0d exp 1", i, count0); else passed++;
            end
            if (i < 40) begin
                s0.tvalid = 1; s0.tdata = 8'(8'h40 + i);
            end else begin
                s0.tvalid = 0;
            end
        end
        @(negedge clk);
        checks++; if (count0 !== 5'd0) $display("FAIL b2b_count_end got %0d exp 0", count0); else passed++;
    endtask

    task automatic test_frame_hold();
        m1.tready = 1;
        s1.tuser = 0;
        for (int i = 0; i <= 7; i++) begin
            @(negedge clk);
            if (i >= 1 && i <= 3) begin
                checks++; if (m1.tvalid !== 1'b0) $display("FAIL fh_hold[%0d] got %b exp 0", i, m1.tvalid); else passed++;
            end
            if (i == 3) begin
                checks++; if (count1 !== 5'd3) $display("FAIL fh_count got %0d exp 3", count1); else passed++;
            end
            if (i >= 4) begin
                checks++; if (m1.tvalid !== 1'b1) $display("FAIL fh_tvalid[%0d] got %b exp 1", i, m1.tvalid); else passed++;
                checks++; if (m1.tdata !== 8'(8'h2d + i)) $display("FAIL fh_data[%0d] got %h exp %h", i, m1.tdata, 8'(8'h2d + i)); else passed++;
                checks++; if (m1.tlast !== (i == 7)) $display("FAIL fh_tlast[%0d] got %b exp %b", i, m1.tlast, (i == 7)); else passed++;
            end
            if (i < 4) begin
                s1.tvalid = 1; s1.tdata = 8'(8'h31 + i); s1.tlast = (i == 3);
            end else begin
                s1.tvalid = 0; s1.tlast = 0;
            end
        end
        @(negedge clk);
        checks++; if (m1.tvalid !== 1'b0) $display("FAIL fh_tvalid_end got %b exp 0", m1.tvalid); else passed++;
        checks++; if (count1 !== 5'd0) $display("FAIL fh_count_end got %0d exp 0", count1); else passed++;
    endtask

    task automatic test_frame_oversize();
        int wi;
        int ri;
        logic [7:0] got [12];
        logic       gotl [12];
        wi = 0; ri = 0;
        m2.tready = 1;
        s2.tuser = 0;
        for (int c = 0; c < 100 && ri < 12; c++) begin
            @(negedge clk);
            if (m2.tvalid) begin
                if (ri == 0) begin
                    checks++; if (full2 !== 1'b1) $display("FAIL ov_first_valid_full got %b exp 1", full2); else passed++;
                end
                if (ri < 12) begin
                    got[ri] = m2.tdata; gotl[ri] = m2.tlast;
                end
                ri++;
            end
            if (wi < 12) begin
                s2.tvalid = 1; s2.tdata = 8'(8'h50 + wi); s2.tlast = (wi == 11);
                if (s2.tready) wi++;
            end else begin
                s2.tvalid = 0; s2.tlast = 0;
            end
        end
        s2.tvalid = 0; s2.tlast = 0;
        checks++; if (ri !== 12) $display("FAIL ov_beats_out got %0d exp 12", ri); else passed++;
        if (ri == 12) begin
            for (int j = 0; j < 12; j++) begin
                checks++; if (got[j] !== 8'(8'h50 + j)) $display("FAIL ov_data[%0d] got %h exp %h", j, got[j], 8'(8'h50 + j)); else passed++;
                checks++; if (gotl[j] !== (j == 11)) $display("FAIL ov_tlast[%0d] got %b exp %b", j, gotl[j], (j == 11)); else passed++;
            end
        end
        @(negedge clk);
        checks++; if (count2 !== 4'd0) $display("FAIL ov_count_end got %0d exp 0", count2); else passed++;
        checks++; if (m2.tvalid !== 1'b0) $display("FAIL ov_tvalid_end got %b exp 0", m2.tvalid); else passed++;
    endtask

    task automatic test_reset_mid_frame();
        m1.tready = 0;
        s1.tuser = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            s1.tvalid = 1; s1.tdata = 8'(8'h61 + i); s1.tlast = 0;
        end
        @(negedge clk);
        s1.tvalid = 0;
        checks++; if (count1 !== 5'd5) $display("FAIL rm_count_pre got %0d exp 5", count1); else passed++;
        checks++; if (m1.tvalid !== 1'b0) $display("FAIL rm_tvalid_pre got %b exp 0", m1.tvalid); else passed++;
        rst_n = 0;
        #1;
        checks++; if (s1.tready !== 1'b0) $display("FAIL rm_tready_in_rst got %b exp 0", s1.tready); else passed++;
        @(negedge clk);
        checks++; if (count1 !== 5'd0) $display("FAIL rm_count got %0d exp 0", count1); else passed++;
        checks++; if (empty1 !== 1'b1) $display("FAIL rm_empty got %b exp 1", empty1); else passed++;
        checks++; if (full1 !== 1'b0) $display("FAIL rm_full got %b exp 0", full1); else passed++;
        checks++; if (m1.tvalid !== 1'b0) $display("FAIL rm_tvalid got %b exp 0", m1.tvalid); else passed++;
        rst_n = 1;
        s1.tvalid = 1; s1.tdata = 8'hAA; s1.tlast = 1;
        m1.tready = 1;
        @(negedge clk);
        s1.tvalid = 0; s1.tlast = 0;
        checks++; if (m1.tvalid !== 1'b1) $display("FAIL rm_new_tvalid got %b exp 1", m1.tvalid); else passed++;
        checks++; if (m1.tdata !== 8'hAA) $display("FAIL rm_new_data got %h exp aa", m1.tdata); else passed++;
        checks++; if (m1.tlast !== 1'b1) $display("FAIL rm_new_tlast got %b exp 1", m1.tlast); else passed++;
        checks++; if (count1 !== 5'd1) $display("FAIL rm_new_count got %0d exp 1", count1); else passed++;
        @(negedge clk);
        checks++; if (m1.tvalid !== 1'b0) $display("FAIL rm_alone got %b exp 0", m1.tvalid); else passed++;
        checks++; if (count1 !== 5'd0) $display("FAIL rm_count_end got %0d exp 0", count1); else passed++;
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_fill();
        test_back_to_back();
        test_frame_hold();
        test_frame_oversize();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
